// File: rtl/hold_pkg.sv
// Shared types and helpers for the hold_detector button front end.
// Used by hold_channel and hold_detector. The optional auto-repeat
// feature is enabled by defining HOLD_REPEAT_EN.
package hold_pkg;

    // Largest number of channels one hold_detector may carry.
    localparam int MAX_CH = 32;

    // Per-channel press classifier states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } hold_state_t;

    // Convert a duration in milliseconds to clock cycles.
    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    // Counter width wide enough for the largest of the three cycle counts.
    function automatic int cnt_width(input int deb_cyc, input int hold_cyc, input int rep_cyc);
        int m;
        m = deb_cyc;
        if (hold_cyc > m) m = hold_cyc;
        if (rep_cyc > m) m = rep_cyc;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/hold_channel.sv
// One button channel: 2-FF synchroniser, debounce filter and the
// short/long press classifier. Define HOLD_REPEAT_EN to make long_o
// re-pulse every REP_CYC cycles while the button stays held.
module hold_channel
    import hold_pkg::*;
#(
    parameter int DEB_CYC     = 3,
    parameter int HOLD_CYC    = 10,
`ifdef HOLD_REPEAT_EN
    parameter int REP_CYC     = 4,
`endif
    parameter int CNT_W       = 5,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_o,
    output logic short_o,
    output logic long_o,
    output logic held_o
);

    // Pin level when the button is released; also the synchroniser reset
    // value so that reset never looks like a press.
    localparam logic             IDLE_LVL  = (ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
`ifdef HOLD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
`endif

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             s;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             rise, fall;

    hold_state_t      state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             held_q, held_d;
`ifdef HOLD_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Synchroniser and debounce next-state: the debounced level flips once
    // the synchronised level has disagreed with it for DEB_CYC cycles.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        s         = sync2_q ^ IDLE_LVL;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (s != deb_q) begin
            if (deb_cnt_q >= DEB_LAST) begin
                deb_d     = ~deb_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = (deb_cnt_q == CNT_MAX) ? deb_cnt_q : deb_cnt_q + CNT_W'(1);
            end
        end
        rise = deb_d & ~deb_q;
        fall = ~deb_d & deb_q;
    end

    // Synchroniser and debounce registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= IDLE_LVL;
            sync2_q   <= IDLE_LVL;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Classifier next-state; a release always beats a hold/repeat event.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        short_d    = 1'b0;
        long_d     = 1'b0;
`ifdef HOLD_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise && !fall) begin
                    state_d    = PRESSED;
                    hold_cnt_d = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    state_d   = HELD;
                    long_d    = 1'b1;
`ifdef HOLD_REPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    hold_cnt_d = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end
`ifdef HOLD_REPEAT_EN
                else if (rep_cnt_q >= REP_LAST) begin
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = (rep_cnt_q == CNT_MAX) ? rep_cnt_q : rep_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        held_d = (state_d == HELD);
    end

    // Classifier FSM with registered event/level outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
`ifdef HOLD_REPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            short_q    <= short_d;
            long_q     <= long_d;
            held_q     <= held_d;
`ifdef HOLD_REPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
`endif
        end
    end

    assign press_o = deb_q;
    assign short_o = short_q;
    assign long_o  = long_q;
    assign held_o  = held_q;

endmodule

// File: rtl/hold_detector.sv
// Multi-channel press/hold detector: N_CH independent hold_channel
// instances sharing one timing configuration. Define HOLD_REPEAT_EN to
// enable auto-repeat of long_o while a button stays held.
module hold_detector
    import hold_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 5000,
    parameter int REPEAT_MS   = 500,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] short_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] held_o
);

    localparam int DEB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int HOLD_CYC = ms_to_cyc(CLK_HZ, HOLD_MS);
    localparam int REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
    localparam int CNT_W    = cnt_width(DEB_CYC, HOLD_CYC, REP_CYC);

    // Reject configurations that cannot be classified sensibly.
    if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_nch
        $error("hold_detector: N_CH must be 1..32");
    end
    if (DEB_CYC <= 0 || HOLD_CYC <= 0 || REP_CYC <= 0) begin : g_bad_cyc
        $error("hold_detector: derived cycle counts must be non-zero");
    end
    if (HOLD_CYC <= DEB_CYC) begin : g_bad_hold
        $error("hold_detector: hold time must exceed debounce time");
    end
    if (ACTIVE_HIGH != 0 && ACTIVE_HIGH != 1) begin : g_bad_pol
        $error("hold_detector: ACTIVE_HIGH must be 0 or 1");
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        hold_channel #(
            .DEB_CYC     (DEB_CYC),
            .HOLD_CYC    (HOLD_CYC),
`ifdef HOLD_REPEAT_EN
            .REP_CYC     (REP_CYC),
`endif
            .CNT_W       (CNT_W),
            .ACTIVE_HIGH (ACTIVE_HIGH)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (btn_raw[gi]),
            .press_o (press_o[gi]),
            .short_o (short_o[gi]),
            .long_o  (long_o[gi]),
            .held_o  (held_o[gi])
        );
    end

endmodule
